nco_div_multi: RTL and testbench
================================

// Module: nco_div_multi
// PURPOSE
//  Multi-channel numerically controlled frequency divider.
//  A shared prescaler derives a single-cycle tick enable at TICK_HZ from clk_50m; no derived clocks.
//  CH independent 2^DW-modulo reload counters divide that tick rate.
//  Each channel has shadowed divisor loading (glitch-free update at wrap), enable, and square/pulse output mode.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  TICK_HZ  50_000      prescaler tick rate; PRE = CLK_HZ/TICK_HZ, must be >= 2 (elaboration check)
//  CH       4           number of channels
//  DW       8           divisor/counter width per channel; MAX = 2^DW-1
// PORTS
//  clk_50m  in   1      system clock, all logic on posedge
//  reset    in   1      asynchronous, active-high reset
//  d        in   CH*DW  reload values; channel i uses d[i*DW +: DW]
//  ld       in   CH     load strobe per channel: capture d slice into shadow
//  en       in   CH     channel enable; counter advances only when 1
//  mode     in   CH     0 = toggle (square wave), 1 = pulse (one clk wide)
//  fout     out  CH     divided outputs, registered
//  pending  out  CH     1 = shadow loaded, not yet applied
//  tick     out  1      prescaler enable, high one clk every PRE clks
// BEHAVIOUR
//  Reset (async, any time): pcnt, tick, and all per-channel cnt/act/shadow/pending/fout = 0.
//  Prescaler
//   - pcnt counts 0..PRE-1 and wraps.
//   - tick is registered 1 on the clk where pcnt==PRE-1; first tick is the PRE-th edge after reset release.
//  Channel i, wrap event W = tick & en[i] & (cnt==MAX), evaluated per clk
//   - tick & en & cnt!=MAX: cnt <= cnt+1.
//   - W: cnt <= (pending ? shadow : act); act <= the same value; pending <= 0.
//   - W uses the shadow value held before this edge.
//   - en=0: cnt holds and pending holds; toggle-mode fout holds; pulse-mode fout is 0.
//  Period
//   - Period in ticks N = 2^DW - act, so act=MAX gives N=1.
//   - First period after reset is 2^DW ticks, since cnt starts at 0.
//  Load
//   - ld[i]: shadow <= d slice and pending <= 1 on the same edge.
//   - Repeated ld before W: last value wins.
//   - ld on the same edge as W: the new value stays pending for one more period.
//  Output, updated on the same edge as W (zero extra latency)
//   - mode=0: fout toggles on W, giving a square wave of period 2N ticks (50% duty).
//   - mode=1: fout = W registered; high exactly one clk per N ticks, 0 otherwise.
//   - mode change takes effect next edge; entering mode=1 forces fout=0 until the next W.
//  Channels are fully independent; simultaneous W on several channels is legal.
//  Width: cnt, act and shadow are DW bits; cnt+1 never exceeds MAX because it reloads at MAX.
// TESTING (bench params CLK_HZ=10, TICK_HZ=1 -> PRE=10; CH=2, DW=8)
//  1. Assert reset mid-run.
//     -> fout, pending, tick = 0 asynchronously.
//     -> After release, first tick on the 10th posedge and every 10 clks after.
//  2. ch0: ld with d=250, en=1, mode=0.
//     -> pending=1 until the first wrap (256 ticks).
//     -> Thereafter fout toggles every 6 ticks (period 120 clks).
//  3. ch1: d=255, mode=1, en=1, after its first wrap.
//     -> fout[1] high one clk every 10 clks, coincident with tick.
//  4. ch0 running with act=250, ld d=252 three ticks after a wrap.
//     -> Current period still 6 ticks; next periods 4 ticks.
//     -> pending falls on the wrap edge.
//  5. ld d=200 on the exact edge of a wrap.
//     -> One more period at the old N; pending stays 1; then N=56.
//  6. Drop en[0] for 20 ticks mid-count.
//     -> cnt and fout[0] freeze; period resumes with the remaining count.
//     -> ch1 is unaffected.

Source files
------------

// File: rtl/nco_div_multi_if.sv
// Control/status bundle for nco_div_multi: per-channel reload data, strobes
// and modes in, divided outputs and prescaler tick back out.
interface nco_div_multi_if #(
   parameter int unsigned CH = 4,
   parameter int unsigned DW = 8
);
   logic [CH*DW-1:0] d;
   logic [CH-1:0]    ld;
   logic [CH-1:0]    en;
   logic [CH-1:0]    mode;
   logic [CH-1:0]    fout;
   logic [CH-1:0]    pending;
   logic             tick;

   modport master (
      output d, ld, en, mode,
      input  fout, pending, tick
   );

   modport slave (
      input  d, ld, en, mode,
      output fout, pending, tick
   );
endinterface

// File: rtl/nco_div_multi.sv
// Multi-channel NCO divider: shared prescaler tick enable feeding CH
// independent 2^DW-modulo reload counters with shadowed divisor loading.
module nco_div_multi #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 50_000,
   parameter int unsigned CH      = 4,
   parameter int unsigned DW      = 8
) (
   input  logic            clk_50m,
   input  logic            reset,
   nco_div_multi_if.slave  bus
);

   localparam int unsigned PRE = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = (PRE > 1) ? $clog2(PRE) : 1;
   localparam logic [DW-1:0] MAX = '1;

   generate
      if (PRE < 2) begin : g_pre_check
         $error("nco_div_multi: CLK_HZ/TICK_HZ must be at least 2");
      end
   endgenerate

   logic [PW-1:0] pcnt;
   logic          tick_en;
   logic          tick_q;

   // Channels consume the pre-register condition so that fout updates on
   // the same edge that raises the registered tick output.
   assign tick_en = (pcnt == PW'(PRE - 1));

   always_ff @(posedge clk_50m or posedge reset) begin
      if (reset) begin
         pcnt   <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_en;
         pcnt   <= tick_en ? '0 : pcnt + 1'b1;
      end
   end

   assign bus.tick = tick_q;

   logic [DW-1:0] cnt    [CH];
   logic [DW-1:0] act    [CH];
   logic [DW-1:0] shadow [CH];
   logic [CH-1:0] pending_q;
   logic [CH-1:0] fout_q;
   logic [CH-1:0] wrap;

   always_comb begin
      wrap = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         wrap[i] = tick_en & bus.en[i] & (cnt[i] == MAX);
      end
   end

   always_ff @(posedge clk_50m or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < CH; i++) begin
            cnt[i]    <= '0;
            act[i]    <= '0;
            shadow[i] <= '0;
         end
         pending_q <= '0;
         fout_q    <= '0;
      end else begin
         for (int unsigned i = 0; i < CH; i++) begin
            if (wrap[i]) begin
               cnt[i]       <= pending_q[i] ? shadow[i] : act[i];
               act[i]       <= pending_q[i] ? shadow[i] : act[i];
               pending_q[i] <= 1'b0;
            end else if (tick_en && bus.en[i]) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
            fout_q[i] <= bus.mode[i] ? wrap[i] : (fout_q[i] ^ wrap[i]);
            // A load on the wrap edge lands after the reload, so it stays pending.
            if (bus.ld[i]) begin
               shadow[i]    <= bus.d[i*DW +: DW];
               pending_q[i] <= 1'b1;
            end
         end
      end
   end

   assign bus.fout    = fout_q;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_nco_div_multi.sv
// Self-checking bench for nco_div_multi: directed scenarios plus random
// stimulus, compared against a period/remaining-ticks reference model.
module tb_nco_div_multi;

   localparam int unsigned PRE = 10;
   localparam int unsigned CH  = 2;
   localparam int unsigned DW  = 8;
   localparam int          FULL = 1 << DW;

   logic clk_50m = 1'b0;
   logic reset   = 1'b1;
   int   tests   = 0;
   int   fails   = 0;

   nco_div_multi_if #(.CH(CH), .DW(DW)) bus ();

   nco_div_multi #(
      .CLK_HZ (10),
      .TICK_HZ(1),
      .CH     (CH),
      .DW     (DW)
   ) dut (
      .clk_50m(clk_50m),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_50m = ~clk_50m;

   // Reference model: each channel tracks its period in ticks and the
   // ticks remaining until its next wrap.
   int         edges;
   bit         m_tick;
   int         rem    [CH];
   int         per    [CH];
   int         shv    [CH];
   bit         m_pend [CH];
   bit         m_fo   [CH];
   logic [1:0] m_fout;
   logic [1:0] m_pending;

   assign m_fout    = {m_fo[1], m_fo[0]};
   assign m_pending = {m_pend[1], m_pend[0]};

   always @(posedge clk_50m or posedge reset) begin
      if (reset) begin
         edges  <= 0;
         m_tick <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            rem[c]    <= FULL;
            per[c]    <= FULL;
            shv[c]    <= 0;
            m_pend[c] <= 1'b0;
            m_fo[c]   <= 1'b0;
         end
      end else begin
         edges  <= edges + 1;
         m_tick <= ((edges + 1) % PRE == 0);
         for (int c = 0; c < CH; c++) begin
            if (((edges + 1) % PRE == 0) && bus.en[c]) begin
               if (rem[c] == 1) begin
                  rem[c]    <= m_pend[c] ? FULL - shv[c] : per[c];
                  per[c]    <= m_pend[c] ? FULL - shv[c] : per[c];
                  m_pend[c] <= 1'b0;
                  m_fo[c]   <= bus.mode[c] ? 1'b1 : ~m_fo[c];
               end else begin
                  rem[c]  <= rem[c] - 1;
                  m_fo[c] <= bus.mode[c] ? 1'b0 : m_fo[c];
               end
            end else begin
               m_fo[c] <= bus.mode[c] ? 1'b0 : m_fo[c];
            end
            if (bus.ld[c]) begin
               shv[c]    <= int'(bus.d[c*DW +: DW]);
               m_pend[c] <= 1'b1;
            end
         end
      end
   end

   task automatic test_reset();
      bit found;
      tests++;
      if ({bus.fout, bus.pending, bus.tick} !== 5'b0) begin
         fails++;
         $display("FAIL reset_init got fout=%b pending=%b tick=%b want all 0", bus.fout, bus.pending, bus.tick);
      end
      #17 reset = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk_50m); #1;
         tests++;
         if (bus.tick !== (k % PRE == 0)) begin
            fails++;
            $display("FAIL tick_phase edge=%0d got %b want %b", k, bus.tick, (k % PRE == 0));
         end
      end
      bus.d[7:0] = 8'd7;
      bus.ld[0]  = 1'b1;
      @(posedge clk_50m); #1;
      bus.ld[0]  = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk_50m); #1;
         if (bus.tick === 1'b1) found = 1'b1;
      end
      tests++;
      if (!found || bus.pending[0] !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset got tick_seen=%b pending0=%b want 1 1", found, bus.pending[0]);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({bus.fout, bus.pending, bus.tick} !== 5'b0) begin
         fails++;
         $display("FAIL async_reset got fout=%b pending=%b tick=%b want all 0", bus.fout, bus.pending, bus.tick);
      end
      @(negedge clk_50m);
      reset = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk_50m); #1;
         tests++;
         if (bus.tick !== (k % PRE == 0) || bus.tick !== m_tick) begin
            fails++;
            $display("FAIL tick_after_reset edge=%0d got %b want %b", k, bus.tick, (k % PRE == 0));
         end
      end
   endtask

   task automatic test_load_toggle();
      logic prev;
      @(negedge clk_50m) reset = 1'b1;
      @(negedge clk_50m) reset = 1'b0;
      bus.d[7:0] = 8'd250;
      bus.ld     = 2'b01;
      bus.en     = 2'b01;
      bus.mode   = 2'b00;
      prev       = 1'b0;
      for (int k = 1; k <= 2750; k++) begin
         @(posedge clk_50m); #1;
         if (k == 1) bus.ld = 2'b00;
         tests++;
         if ({bus.fout, bus.pending, bus.tick} !== {m_fout, m_pending, m_tick}) begin
            fails++;
            $display("FAIL model_load t=%0t got f=%b p=%b t=%b want f=%b p=%b t=%b", $time, bus.fout, bus.pending, bus.tick, m_fout, m_pending, m_tick);
         end
         tests++;
         if (bus.pending[0] !== (k < 2560)) begin
            fails++;
            $display("FAIL load_pending edge=%0d got %b want %b", k, bus.pending[0], (k < 2560));
         end
         tests++;
         if ((bus.fout[0] !== prev) !== (k == 2560 || k == 2620 || k == 2680 || k == 2740)) begin
            fails++;
            $display("FAIL load_toggle edge=%0d got toggle=%b want %b", k, bus.fout[0] !== prev, !(bus.fout[0] !== prev));
         end
         prev = bus.fout[0];
      end
   endtask

   task automatic test_pulse();
      logic prev;
      bit   found;
      bus.d[15:8] = 8'd255;
      bus.ld[1]   = 1'b1;
      bus.mode[1] = 1'b1;
      bus.en[1]   = 1'b1;
      @(posedge clk_50m); #1;
      bus.ld[1] = 1'b0;
      prev  = bus.pending[1];
      found = 1'b0;
      for (int i = 0; i < 2700 && !found; i++) begin
         @(posedge clk_50m); #1;
         tests++;
         if ({bus.fout, bus.pending, bus.tick} !== {m_fout, m_pending, m_tick}) begin
            fails++;
            $display("FAIL model_pulse t=%0t got f=%b p=%b t=%b want f=%b p=%b t=%b", $time, bus.fout, bus.pending, bus.tick, m_fout, m_pending, m_tick);
         end
         if (prev === 1'b1 && bus.pending[1] === 1'b0) found = 1'b1;
         prev = bus.pending[1];
      end
      tests++;
      if (!found || bus.fout[1] !== 1'b1) begin
         fails++;
         $display("FAIL pulse_first_wrap got seen=%b fout1=%b want 1 1", found, bus.fout[1]);
      end
      for (int i = 0; i < 60; i++) begin
         @(posedge clk_50m); #1;
         tests++;
         if (bus.fout[1] !== bus.tick || bus.fout[1] !== m_fout[1]) begin
            fails++;
            $display("FAIL pulse_with_tick t=%0t got fout1=%b want %b", $time, bus.fout[1], m_fout[1]);
         end
      end
   endtask

   task automatic test_reload_midperiod();
      logic prev;
      bit   found;
      prev  = bus.fout[0];
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk_50m); #1;
         if (bus.fout[0] !== prev) found = 1'b1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL reload_wait got no toggle want toggle within 200 clks");
      end
      prev       = bus.fout[0];
      bus.d[7:0] = 8'd252;
      for (int j = 1; j <= 145; j++) begin
         bus.ld[0] = (j == 31);
         @(posedge clk_50m); #1;
         tests++;
         if ({bus.fout, bus.pending, bus.tick} !== {m_fout, m_pending, m_tick}) begin
            fails++;
            $display("FAIL model_reload t=%0t got f=%b p=%b t=%b want f=%b p=%b t=%b", $time, bus.fout, bus.pending, bus.tick, m_fout, m_pending, m_tick);
         end
         tests++;
         if ((bus.fout[0] !== prev) !== (j == 60 || j == 100 || j == 140)) begin
            fails++;
            $display("FAIL reload_toggle clk=%0d got toggle=%b want %b", j, bus.fout[0] !== prev, (j == 60 || j == 100 || j == 140));
         end
         tests++;
         if (bus.pending[0] !== (j >= 31 && j < 60)) begin
            fails++;
            $display("FAIL reload_pending clk=%0d got %b want %b", j, bus.pending[0], (j >= 31 && j < 60));
         end
         prev = bus.fout[0];
      end
      bus.ld[0] = 1'b0;
   endtask

   task automatic test_ld_at_wrap();
      logic prev;
      bit   found;
      prev  = bus.fout[0];
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk_50m); #1;
         if (bus.fout[0] !== prev) found = 1'b1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL ldwrap_wait got no toggle want toggle within 100 clks");
      end
      prev       = bus.fout[0];
      bus.d[7:0] = 8'd200;
      for (int j = 1; j <= 645; j++) begin
         bus.ld[0] = (j == 40);
         @(posedge clk_50m); #1;
         tests++;
         if ({bus.fout, bus.pending, bus.tick} !== {m_fout, m_pending, m_tick}) begin
            fails++;
            $display("FAIL model_ldwrap t=%0t got f=%b p=%b t=%b want f=%b p=%b t=%b", $time, bus.fout, bus.pending, bus.tick, m_fout, m_pending, m_tick);
         end
         tests++;
         if ((bus.fout[0] !== prev) !== (j == 40 || j == 80 || j == 640)) begin
            fails++;
            $display("FAIL ldwrap_toggle clk=%0d got toggle=%b want %b", j, bus.fout[0] !== prev, (j == 40 || j == 80 || j == 640));
         end
         tests++;
         if (bus.pending[0] !== (j >= 40 && j < 80)) begin
            fails++;
            $display("FAIL ldwrap_pending clk=%0d got %b want %b", j, bus.pending[0], (j >= 40 && j < 80));
         end
         prev = bus.fout[0];
      end
      bus.ld[0] = 1'b0;
   endtask

   task automatic test_enable_hold();
      logic prev;
      bit   found;
      prev  = bus.fout[0];
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(posedge clk_50m); #1;
         if (bus.fout[0] !== prev) found = 1'b1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL enable_wait got no toggle want toggle within 600 clks");
      end
      prev = bus.fout[0];
      for (int j = 1; j <= 770; j++) begin
         bus.en[0] = !(j > 200 && j <= 400);
         @(posedge clk_50m); #1;
         tests++;
         if ({bus.fout, bus.pending, bus.tick} !== {m_fout, m_pending, m_tick}) begin
            fails++;
            $display("FAIL model_enable t=%0t got f=%b p=%b t=%b want f=%b p=%b t=%b", $time, bus.fout, bus.pending, bus.tick, m_fout, m_pending, m_tick);
         end
         tests++;
         if ((bus.fout[0] !== prev) !== (j == 760)) begin
            fails++;
            $display("FAIL enable_toggle clk=%0d got toggle=%b want %b", j, bus.fout[0] !== prev, (j == 760));
         end
         tests++;
         if (bus.fout[1] !== bus.tick) begin
            fails++;
            $display("FAIL enable_ch1 clk=%0d got fout1=%b want %b", j, bus.fout[1], bus.tick);
         end
         prev = bus.fout[0];
      end
      bus.en[0] = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++) begin
            bus.ld[c] = ($urandom_range(15) == 0);
            bus.d[c*DW +: DW] = 8'(240 + $urandom_range(15));
            if ($urandom_range(31) == 0) bus.en[c] = ~bus.en[c];
            if ($urandom_range(63) == 0) bus.mode[c] = ~bus.mode[c];
         end
         @(posedge clk_50m); #1;
         tests++;
         if ({bus.fout, bus.pending, bus.tick} !== {m_fout, m_pending, m_tick}) begin
            fails++;
            $display("FAIL model_random t=%0t got f=%b p=%b t=%b want f=%b p=%b t=%b", $time, bus.fout, bus.pending, bus.tick, m_fout, m_pending, m_tick);
         end
      end
      bus.ld = 2'b00;
   endtask

   initial begin
      bus.d    = '0;
      bus.ld   = '0;
      bus.en   = '0;
      bus.mode = '0;
      #5;
      test_reset();
      test_load_toggle();
      test_pulse();
      test_reload_midperiod();
      test_ld_at_wrap();
      test_enable_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
